pulse_period_meter: RTL
=======================

PULSE_PERIOD_METER -- requirements
Module: pulse_period_meter

Interface
REQ-001 SHALL have parameter MAX_PERIOD, default 25000000, longest measurable period in clk cycles (>= 2).
REQ-002 SHALL have local width W = ceil(log2(MAX_PERIOD+1)), so that MAX_PERIOD fits in W bits.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port en  input  1  measurement enable; low forces IDLE.
REQ-006 SHALL have port pulse_in  input  1  tick stream, synchronous to clk (e.g. a single-cycle slow-clock strobe).
REQ-007 SHALL have port period  output  W  last measured interval in clk cycles between consecutive pulse_in rising edges.
REQ-008 SHALL have port period_valid  output  1  one-cycle strobe; period was updated this cycle.
REQ-009 SHALL have port locked  output  1  high while the last two measured periods are equal.
REQ-010 SHALL have port timeout  output  1  sticky; no edge arrived within MAX_PERIOD cycles.

Function
REQ-011 SHALL register pulse_in into prev each cycle; edge = pulse_in & ~prev, evaluated at each clk rising edge.
REQ-012 SHALL count a pulse_in held high for several cycles as one edge only.
REQ-013 SHALL implement states IDLE and MEAS, held in a registered state variable.
REQ-014 IDLE: cnt held at 0; on edge with en=1 -> MEAS with cnt <= 1; period_valid stays 0.
REQ-015 MEAS, no edge, cnt < MAX_PERIOD: cnt <= cnt + 1.
REQ-016 MEAS, edge: period <= cnt, period_valid <= 1 for exactly the next cycle, cnt <= 1, and the state stays MEAS.
REQ-017 Latency: edges at sampling clocks t0 and t0+N SHALL yield period = N and period_valid high in the cycle after clock t0+N.
REQ-018 MEAS, edge with cnt == MAX_PERIOD: the edge SHALL win; the block reports period = MAX_PERIOD and no timeout.
REQ-019 MEAS, no edge with cnt == MAX_PERIOD -> IDLE, cnt <= 0, timeout <= 1, locked <= 0; the counter SHALL never wrap.
REQ-020 timeout SHALL stay high until the next period_valid (cleared in the same cycle period_valid rises) or rst.
REQ-021 An internal register last_period SHALL store each reported period.
REQ-022 On each period_valid, locked <= (new period == last_period) and last_period <= new period.
REQ-023 The first period after leaving IDLE SHALL set last_period but SHALL clear locked.
REQ-024 en low in any state: next state IDLE, cnt <= 0, locked <= 0, no period_valid; period and timeout hold.
REQ-025 en rising with pulse_in already high SHALL NOT create an edge unless prev was 0.
REQ-026 period SHALL hold its value between strobes.
REQ-027 Minimum reportable period is 2, because a single-cycle pulse needs one low cycle between pulses.

Reset
REQ-028 rst=1 at a clock SHALL force state IDLE, cnt=0, prev=0, period=0, period_valid=0, locked=0, timeout=0, last_period=0.
REQ-029 rst SHALL take priority over en and edge in the same cycle.
REQ-030 rst asserted mid-measurement SHALL discard the partial count; the first edge after reset only arms the block.

Verification
REQ-031 MAX_PERIOD=25, en=1, one-cycle pulse every 5 clks -> 1st pulse: none; 2nd: period=5, valid, locked=0; 3rd: period=5, locked=1.
REQ-032 Pulse spacing 5,5,7 -> after the 7-spaced edge: period=7, locked=0; timeout=0 throughout.
REQ-033 MAX_PERIOD=8, one pulse then none -> timeout=1 exactly 8 clks after the arming edge, state IDLE; next two pulses 4 apart -> period=4, timeout=0.
REQ-034 MAX_PERIOD=8, pulses exactly 8 apart -> period=8 every interval and timeout never asserts.
REQ-035 pulse_in held high 3 cycles per 10-cycle spacing -> period=10, one period_valid per interval.
REQ-036 rst pulse at cnt=3 mid-interval, then pulses 6 apart -> first post-reset edge gives no valid; second gives period=6; all outputs 0 during reset.

Source files
------------

// File: rtl/pulse_period_meter.sv
// pulse_period_meter
// Measures the interval, in clk cycles, between consecutive rising edges of
// a clk-synchronous tick stream and reports when that interval is stable.
//
// Ports
//   clk          in   sole clock, all state updates on its rising edge
//   rst          in   synchronous active-high reset
//   en           in   measurement enable; low parks the block in IDLE
//   pulse_in     in   tick stream synchronous to clk
//   period       out  last measured interval (W bits), holds between strobes
//   period_valid out  one-cycle strobe, period was updated this cycle
//   locked       out  high while the last two measured periods are equal
//   timeout      out  sticky, no edge arrived within MAX_PERIOD cycles
module pulse_period_meter #(
  parameter int MAX_PERIOD = 25000000,
  localparam int W = $clog2(MAX_PERIOD + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         pulse_in,
  output logic [W-1:0] period,
  output logic         period_valid,
  output logic         locked,
  output logic         timeout
);

  typedef enum logic {
    IDLE = 1'b0,
    MEAS = 1'b1
  } state_t;

  localparam logic [W-1:0] CNT_MAX = W'(MAX_PERIOD);
  localparam logic [W-1:0] CNT_ONE = W'(1);

  state_t       state_reg;
  logic [W-1:0] cnt_reg;
  logic         prev_reg;
  logic [W-1:0] period_reg;
  logic         valid_reg;
  logic         locked_reg;
  logic         timeout_reg;
  logic [W-1:0] last_period_reg;
  // Set while the next reported period is the first since leaving IDLE;
  // that period has nothing valid to be compared against.
  logic         first_reg;

  logic         rise;

  // A pulse held high for several cycles yields a single rise.
  assign rise = pulse_in & ~prev_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= IDLE;
      cnt_reg         <= '0;
      prev_reg        <= 1'b0;
      period_reg      <= '0;
      valid_reg       <= 1'b0;
      locked_reg      <= 1'b0;
      timeout_reg     <= 1'b0;
      last_period_reg <= '0;
      first_reg       <= 1'b0;
    end else begin
      // prev tracks pulse_in regardless of en, so raising en while the
      // pulse is already high does not fabricate an edge.
      prev_reg  <= pulse_in;
      valid_reg <= 1'b0;
      if (!en) begin
        state_reg  <= IDLE;
        cnt_reg    <= '0;
        locked_reg <= 1'b0;
      end else begin
        case (state_reg)
          IDLE: begin
            cnt_reg <= '0;
            if (rise) begin
              // Arming edge: no period yet, counting starts here.
              state_reg <= MEAS;
              cnt_reg   <= CNT_ONE;
              first_reg <= 1'b1;
            end
          end
          MEAS: begin
            if (rise) begin
              // An edge landing exactly at cnt == MAX_PERIOD still counts
              // as a valid measurement, so this branch comes first.
              period_reg      <= cnt_reg;
              valid_reg       <= 1'b1;
              timeout_reg     <= 1'b0;
              last_period_reg <= cnt_reg;
              locked_reg      <= first_reg ? 1'b0 : (cnt_reg == last_period_reg);
              first_reg       <= 1'b0;
              cnt_reg         <= CNT_ONE;
            end else if (cnt_reg < CNT_MAX) begin
              cnt_reg <= cnt_reg + CNT_ONE;
            end else begin
              // Interval exceeded: drop back to IDLE instead of wrapping.
              state_reg   <= IDLE;
              cnt_reg     <= '0;
              timeout_reg <= 1'b1;
              locked_reg  <= 1'b0;
            end
          end
          default: begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
          end
        endcase
      end
    end
  end

  assign period       = period_reg;
  assign period_valid = valid_reg;
  assign locked       = locked_reg;
  assign timeout      = timeout_reg;

endmodule
